// File: rtl/ez8_pkg.sv
// Shared constants for the ez8 front end: widths, instruction field
// positions, opcode values and kill-vector bit indices.
package ez8_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 16;

  // Instruction layout: opcode | dst | srcA | srcB, each one nibble.
  localparam int FIELD_W  = 4;
  localparam int OP_LSB   = 12;
  localparam int DST_LSB  = 8;
  localparam int SRCA_LSB = 4;
  localparam int SRCB_LSB = 0;

  localparam logic [FIELD_W-1:0] OP_NOP    = 4'h0;
  localparam logic [FIELD_W-1:0] OP_MOV    = 4'h1;
  localparam logic [FIELD_W-1:0] OP_ADD    = 4'h2;
  localparam logic [FIELD_W-1:0] OP_SUB    = 4'h3;
  localparam logic [FIELD_W-1:0] OP_LOAD   = 4'hA;
  localparam logic [FIELD_W-1:0] OP_STORE  = 4'hB;
  localparam logic [FIELD_W-1:0] OP_BRANCH = 4'hC;
  localparam logic [FIELD_W-1:0] LOAD_OP   = OP_LOAD;

  // Bit positions inside the kill vector from the PC controller.
  localparam int KILL_F = 2;
  localparam int KILL_D = 1;
  localparam int KILL_E = 0;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector: flags a valid D-stage instruction that reads
// the destination register of a valid load sitting in E.
module hazard_unit #(
  parameter int               INSTR_W = ez8_pkg::INSTR_W,
  parameter logic [3:0]       LOAD_OP = ez8_pkg::LOAD_OP
) (
  input  logic [INSTR_W-1:0] dec_instr,
  input  logic               dec_valid,
  input  logic [INSTR_W-1:0] ex_instr,
  input  logic               ex_valid,
  output logic               hazard
);
  import ez8_pkg::*;

  logic ex_is_load;
  logic src_match;

  // Decode the E opcode and compare both D source fields with the E destination.
  always_comb begin
    ex_is_load = (ex_instr[OP_LSB +: FIELD_W] == LOAD_OP);
    src_match  = (dec_instr[SRCA_LSB +: FIELD_W] == ex_instr[DST_LSB +: FIELD_W]) ||
                 (dec_instr[SRCB_LSB +: FIELD_W] == ex_instr[DST_LSB +: FIELD_W]);
    hazard     = ex_valid && ex_is_load && dec_valid && src_match;
  end

endmodule

// File: rtl/fetch_pipe.sv
// Front-end pipeline: drives the instruction ROM address from the PC,
// carries instructions through F, D and E registers with valid bits, and
// raises pause to the PC controller on a load-use hazard or external stall.
//
// Handshake: pause is a hold request. While pause=1 the PC controller keeps
// pc_in constant, F and D hold their data, and E is filled with a bubble.
// kill bits always gate the valid bit loaded at the next edge, paused or not.
module fetch_pipe #(
  parameter int         PC_W    = ez8_pkg::PC_W,
  parameter int         INSTR_W = ez8_pkg::INSTR_W,
  parameter logic [3:0] LOAD_OP = ez8_pkg::LOAD_OP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [2:0]         kill,
  input  logic               stall_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               pause,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] ex_instr,
  output logic [PC_W-1:0]    ex_pc,
  output logic               ex_valid
);
  import ez8_pkg::*;

  logic [PC_W-1:0]    f_pc;
  logic               f_valid;
  logic [INSTR_W-1:0] f_hold;
  logic               f_hold_valid;
  logic [INSTR_W-1:0] f_instr;
  logic               hazard;

  // The ROM address follows the PC directly; the ROM supplies the latency.
  assign imem_addr = pc_in;
  assign pause     = hazard | stall_req;

  // The ROM registers its address every edge, so across a paused edge it
  // advances to the word after the one F owns (the held PC is already one
  // ahead). F therefore keeps its own copy of the word from the first paused
  // edge until the pipe moves again.
  assign f_instr = f_hold_valid ? f_hold : imem_data;

  hazard_unit #(
    .INSTR_W (INSTR_W),
    .LOAD_OP (LOAD_OP)
  ) u_hazard (
    .dec_instr (dec_instr),
    .dec_valid (dec_valid),
    .ex_instr  (ex_instr),
    .ex_valid  (ex_valid),
    .hazard    (hazard)
  );

  // F stage: capture PC every moving cycle, hold (and snapshot the ROM word) while paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc         <= '0;
      f_valid      <= 1'b0;
      f_hold       <= '0;
      f_hold_valid <= 1'b0;
    end else if (pause) begin
      f_valid <= f_valid & ~kill[KILL_F];
      if (!f_hold_valid) begin
        f_hold       <= imem_data;
        f_hold_valid <= 1'b1;
      end
    end else begin
      f_pc         <= pc_in;
      f_valid      <= ~kill[KILL_F];
      f_hold_valid <= 1'b0;
    end
  end

  // D stage: take F when moving, hold data while paused; kill still clears valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_instr <= '0;
      dec_pc    <= '0;
      dec_valid <= 1'b0;
    end else if (pause) begin
      dec_valid <= dec_valid & ~kill[KILL_D];
    end else begin
      dec_instr <= f_instr;
      dec_pc    <= f_pc;
      dec_valid <= f_valid & ~kill[KILL_D];
    end
  end

  // E stage: take D when moving, load a zeroed bubble while paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_instr <= '0;
      ex_pc    <= '0;
      ex_valid <= 1'b0;
    end else if (pause) begin
      ex_instr <= '0;
      ex_pc    <= '0;
      ex_valid <= 1'b0;
    end else begin
      ex_instr <= dec_instr;
      ex_pc    <= dec_pc;
      ex_valid <= dec_valid & ~kill[KILL_E];
    end
  end

endmodule

// File: tb/tb_fetch_pipe.sv
// Bench for fetch_pipe: a PC controller model that holds on pause, a
// synchronous ROM model, and a queue of expected {pc, instr} pairs that
// must leave E with ex_valid=1, in order.
module tb_fetch_pipe;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 16;
  localparam int SB_W    = PC_W + INSTR_W;

  logic               clk;
  logic               reset;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_rst;
  logic [2:0]         kill;
  logic               stall_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] rom_q;
  logic               pause;
  logic [INSTR_W-1:0] dec_instr;
  logic [PC_W-1:0]    dec_pc;
  logic               dec_valid;
  logic [INSTR_W-1:0] ex_instr;
  logic [PC_W-1:0]    ex_pc;
  logic               ex_valid;

  logic [INSTR_W-1:0] rom [0:4095];
  logic [SB_W-1:0]    exp_q[$];

  int n_checks;
  int n_pass;
  int n_fail;

  fetch_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc),
    .kill      (kill),
    .stall_req (stall_req),
    .imem_addr (imem_addr),
    .imem_data (rom_q),
    .pause     (pause),
    .dec_instr (dec_instr),
    .dec_pc    (dec_pc),
    .dec_valid (dec_valid),
    .ex_instr  (ex_instr),
    .ex_pc     (ex_pc),
    .ex_valid  (ex_valid)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC controller model: advances by one unless paused
  always @(posedge clk or posedge reset) begin
    if (reset) pc <= pc_rst;
    else if (!pause) pc <= pc + 12'd1;
  end

  // Synchronous ROM with one cycle of read latency
  always @(posedge clk) rom_q <= rom[imem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_rom(input logic [INSTR_W-1:0] word5);
    for (int i = 0; i < 4096; i++) rom[i] = 16'h1000 + 16'(i);
    rom[4] = 16'hA300;
    rom[5] = word5;
  endtask

  task automatic push_pc(input logic [PC_W-1:0] p);
    exp_q.push_back({p, rom[p]});
  endtask

  // Advance one clock, sample 1 time unit later, score E output
  task automatic step();
    logic [SB_W-1:0] want;
    @(posedge clk);
    #1;
    check("imem_addr", 32'(imem_addr), 32'(pc));
    if (ex_valid) begin
      n_checks++;
      assert (exp_q.size() != 0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL sb_extra observed ex_pc=%h expected no valid E", ex_pc);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("sb_ex", 32'({ex_pc, ex_instr}), 32'(want));
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    kill      = 3'b000;
    stall_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pause", 32'(pause), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'(pc_rst));
  endtask

  initial begin
    logic exp_pause;
    n_checks  = 0;
    n_pass    = 0;
    n_fail    = 0;
    pc_rst    = '0;
    reset     = 1'b1;
    kill      = 3'b000;
    stall_req = 1'b0;

    // Phase A: kill on first cycle, load-use, 3-cycle stall, branch flush.
    // Slot pc 0 is killed in F; 9 and 10 are flushed.
    load_rom(16'h2130);
    exp_q.delete();
    for (int p = 1; p <= 8; p++) push_pc(PC_W'(p));
    for (int p = 11; p <= 14; p++) push_pc(PC_W'(p));
    do_reset();
    check("rst_dec_pc", 32'(dec_pc), 32'd0);
    check("rst_ex_pc", 32'(ex_pc), 32'd0);
    reset = 1'b0;
    kill  = 3'b110;
    for (int e = 0; e <= 20; e++) begin
      step();
      if (e == 0)  kill = 3'b000;
      if (e == 9)  stall_req = 1'b1;
      if (e == 12) stall_req = 1'b0;
      if (e == 14) kill = 3'b011;
      if (e == 15) kill = 3'b000;
      #1;
      exp_pause = (e == 6) || (e >= 9 && e <= 11);
      check($sformatf("a_pause_e%0d", e), 32'(pause), 32'(exp_pause));
      if (e == 0) check("a_dec_valid_e0", 32'(dec_valid), 32'd0);
      if (e == 1) begin
        check("a_dec_valid_e1", 32'(dec_valid), 32'd0);
        check("a_dec_pc_e1", 32'(dec_pc), 32'd0);
      end
      if (e == 2) begin
        check("a_dec_valid_e2", 32'(dec_valid), 32'd1);
        check("a_dec_pc_e2", 32'(dec_pc), 32'd1);
        check("a_ex_valid_e2", 32'(ex_valid), 32'd0);
      end
      if (e == 3) begin
        check("a_dec_pc_e3", 32'(dec_pc), 32'd2);
        check("a_ex_pc_e3", 32'(ex_pc), 32'd1);
      end
      if (e == 6) begin
        check("a_hz_ex_pc", 32'(ex_pc), 32'd4);
        check("a_hz_dec_pc", 32'(dec_pc), 32'd5);
      end
      if (e == 7) begin
        check("a_hz_bubble", 32'(ex_valid), 32'd0);
        check("a_hz_dec_hold", 32'(dec_pc), 32'd5);
      end
      if (e == 8) begin
        check("a_hz_ex_valid", 32'(ex_valid), 32'd1);
        check("a_hz_ex_pc5", 32'(ex_pc), 32'd5);
      end
      if (e >= 10 && e <= 12) begin
        check($sformatf("a_stall_dec_pc_e%0d", e), 32'(dec_pc), 32'd7);
        check($sformatf("a_stall_bubble_e%0d", e), 32'(ex_valid), 32'd0);
      end
      if (e == 13) check("a_stall_ex_pc7", 32'(ex_pc), 32'd7);
      if (e == 15) begin
        check("a_flush_dec_valid", 32'(dec_valid), 32'd0);
        check("a_flush_ex_valid", 32'(ex_valid), 32'd0);
      end
      if (e == 16) check("a_flush_ex_valid2", 32'(ex_valid), 32'd0);
    end
    check("a_sb_drained", 32'(exp_q.size()), 32'd0);

    // Phase B: load followed by an independent instruction never pauses
    load_rom(16'h2120);
    exp_q.delete();
    for (int p = 0; p <= 8; p++) push_pc(PC_W'(p));
    do_reset();
    reset = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      step();
      #1;
      check($sformatf("b_pause_e%0d", e), 32'(pause), 32'd0);
      if (e == 6) check("b_ex_pc4", 32'(ex_pc), 32'd4);
      if (e == 7) begin
        check("b_ex_pc5", 32'(ex_pc), 32'd5);
        check("b_ex_valid5", 32'(ex_valid), 32'd1);
      end
    end
    check("b_sb_drained", 32'(exp_q.size()), 32'd0);

    // Phase C: asynchronous reset in the middle of a hazard pause
    load_rom(16'h2130);
    exp_q.delete();
    for (int p = 0; p <= 4; p++) push_pc(PC_W'(p));
    do_reset();
    reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      step();
      #1;
      check($sformatf("c_pause_e%0d", e), 32'(pause), 32'(e == 6));
    end
    #2;
    reset = 1'b1;
    #1;
    check("c_async_pause", 32'(pause), 32'd0);
    check("c_async_dec_valid", 32'(dec_valid), 32'd0);
    check("c_async_ex_valid", 32'(ex_valid), 32'd0);
    check("c_sb_drained", 32'(exp_q.size()), 32'd0);

    // Phase D: PC wrap 0xFFF -> 0x000 passes straight through
    pc_rst = 12'hFFE;
    load_rom(16'h2130);
    exp_q.delete();
    push_pc(12'hFFE);
    push_pc(12'hFFF);
    push_pc(12'h000);
    push_pc(12'h001);
    do_reset();
    reset = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      step();
      #1;
      check($sformatf("d_pause_e%0d", e), 32'(pause), 32'd0);
      if (e == 3) begin
        check("d_wrap_dec_pc", 32'(dec_pc), 32'h000);
        check("d_wrap_dec_valid", 32'(dec_valid), 32'd1);
      end
    end
    check("d_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
